sfp_send_scheduler: RTL
=======================

# sfp_send_scheduler

Periodic transmit scheduler for the two SFP packet-send channels. It runs on the 50 MHz system clock and is gated by MAC initialisation and the PHY-reset controller's rx-ready flag. When gated on, it issues fixed-length `cmd_send` pulses, each with a stable RAM start address, to send-packet controls 1 and 2 in a repeating frame. It sits between the top-level status signals and the platform's `send_packet_N_control` conduits, and also provides per-channel send counters for debug.

## Interface
Parameters:
- `PERIOD_1`, default 32'h05F5E100: cycles from frame start to the rising edge of `cmd_send_1_o`.
- `PERIOD_2`, default 32'h06F5E100: cycles from frame start to the rising edge of `cmd_send_2_o`. Must be greater than `PERIOD_1 + PULSE_LEN`.
- `PULSE_LEN`, default 3: width of each `cmd_send` pulse in cycles. Must be at least 1.
- `GAP`, default 10: idle cycles after pulse 2 before the next frame. Must be at least 1.
- `ADDR_W`, default 25: width of the start-address outputs.
- `START_ADDR_1`, default 1: RAM start address driven for channel 1.
- `START_ADDR_2`, default 1: RAM start address driven for channel 2.

Ports:
- `clk_50`, in, 1: system clock (50 MHz PLL output).
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `mac_inited_i`, in, 1: MAC configuration complete. Synchronous to `clk_50`.
- `rx_ready_i`, in, 1: transceiver rx ready. Asynchronous to `clk_50` (125 MHz domain).
- `cmd_send_1_o`, out, 1: send command for channel 1.
- `cmd_send_2_o`, out, 1: send command for channel 2.
- `start_ram_addr_1_o`, out, `ADDR_W`: channel 1 start address.
- `start_ram_addr_2_o`, out, `ADDR_W`: channel 2 start address.
- `sent_cnt_1_o`, out, 16: number of channel-1 pulses issued.
- `sent_cnt_2_o`, out, 16: number of channel-2 pulses issued.
- `running_o`, out, 1: high when the scheduler is in any state other than IDLE.

## Operation
- `rx_ready_i` passes through a 2-flop synchroniser to produce `rdy_s`. The enable term is `run = mac_inited_i & rdy_s`.
- The FSM has the states IDLE, WAIT_1, SEND_1, WAIT_2, SEND_2 and GAP_ST. A single 32-bit down-counter `cnt` is loaded on every state entry.
- State lengths:
  - WAIT_1: `PERIOD_1` cycles.
  - SEND_1: `PULSE_LEN` cycles.
  - WAIT_2: `PERIOD_2 - PERIOD_1 - PULSE_LEN` cycles.
  - SEND_2: `PULSE_LEN` cycles.
  - GAP_ST: `GAP` cycles. GAP_ST then returns to WAIT_1.
- Frame length is `PERIOD_2 + PULSE_LEN + GAP` cycles.
- IDLE → WAIT_1 when `run` = 1.
- Any state → IDLE on the cycle after `run` is sampled 0. This includes truncating a pulse mid-way. A restart always begins a fresh frame at WAIT_1.
- Output decode:
  - `cmd_send_1_o` is high exactly in SEND_1; `cmd_send_2_o` is high exactly in SEND_2.
  - Both outputs are driven from flops (one-hot state bits or registered decode), never combinational.
- Address outputs:
  - `start_ram_addr_1_o` loads `START_ADDR_1` on the last cycle of WAIT_1, so it is stable at least 1 cycle before the `cmd_send_1_o` rise. It holds that value until the next reset.
  - `start_ram_addr_2_o` behaves the same way, loading on the last cycle of WAIT_2.
- `sent_cnt_N_o` increments on entry to SEND_N and wraps from 16'hFFFF to 0. A truncated pulse still counts.
- Elaboration fails (`$error`) if `PERIOD_2 <= PERIOD_1 + PULSE_LEN`, `PULSE_LEN == 0`, or `GAP == 0`.

## Timing
- Reset (`rst_n` = 0, asynchronous):
  - State is IDLE and `cnt` = 0.
  - All `cmd` outputs, address outputs, `sent_cnt` outputs and `running_o` are 0.
  - Synchroniser flops are 0.
- Start latency:
  - A `rx_ready_i` rise reaches `rdy_s` after 2 edges.
  - WAIT_1 is entered on the 3rd edge, provided `mac_inited_i` is already high.
  - The first `cmd_send_1_o` rise occurs `PERIOD_1` cycles after WAIT_1 entry.
- Stop latency: `run` falling causes all `cmd` outputs to be 0 and `running_o` = 0 after 1 edge (plus 2 edges if the drop comes from `rx_ready_i`).
- The two `cmd` outputs are never high in the same cycle.
- `rst_n` deasserting mid-frame restarts the scheduler in IDLE. No pulse is emitted until `run` is re-established.

## Structure
- The package `sfp_test_pkg` holds:
  - the `send_state_t` enum;
  - the default period, pulse and gap constants, in production and TEST-override sets.
- Sub-module `sync_2ff` (1-bit, asynchronous active-low reset, reset value 0) handles `rx_ready_i`. It is reusable for other cross-domain status bits.

## Test plan
All scenarios use `PERIOD_1`=8, `PERIOD_2`=20, `PULSE_LEN`=3, `GAP`=10, `START_ADDR_1`=5, `START_ADDR_2`=9.
- **Reset values:** hold `rst_n` = 0 with random inputs → every output is 0 throughout.
- **Normal frame:** `mac_inited_i` = 1, then raise `rx_ready_i` → WAIT_1 entered on the 3rd edge. `cmd_send_1_o` is high for frame cycles 8–10 with `start_ram_addr_1_o` = 5 from cycle 7. `cmd_send_2_o` is high for cycles 20–22 with address 9 from cycle 19. The next `cmd_send_1_o` rise comes 33 cycles after the first.
- **Run drop mid-pulse:** drop `mac_inited_i` in the 2nd cycle of SEND_1 → `cmd_send_1_o` is low on the next edge, `running_o` = 0, and `sent_cnt_1_o` = 1. Re-raise it → a fresh frame starts with a full 8-cycle WAIT_1.
- **Counter wrap:** preload via force to `sent_cnt_2_o` = 16'hFFFF and run through SEND_2 → it reads 0.
- **Async reset mid-frame:** pulse `rst_n` low during WAIT_2 → outputs clear immediately without waiting for a clock edge. After release with `run` held, channel 1 fires again 8 cycles after the 3rd edge.
- **Exclusivity:** run 100 frames with random `run` glitches → `cmd_send_1_o & cmd_send_2_o` is never 1, and each counter equals the number of observed rising edges on its `cmd` output.

Source files
------------

// File: rtl/sfp_send_scheduler_pkg.sv
// Shared types and timing constants for the SFP send scheduler.
// Production values target the 50 MHz clock; TEST values give short frames for simulation.
package sfp_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_1,
        SEND_1,
        WAIT_2,
        SEND_2,
        GAP_ST
    } send_state_t;

    localparam logic [31:0] PROD_PERIOD_1  = 32'h05F5E100;
    localparam logic [31:0] PROD_PERIOD_2  = 32'h06F5E100;
    localparam logic [31:0] PROD_PULSE_LEN = 32'd3;
    localparam logic [31:0] PROD_GAP       = 32'd10;

    localparam logic [31:0] TEST_PERIOD_1  = 32'd8;
    localparam logic [31:0] TEST_PERIOD_2  = 32'd20;
    localparam logic [31:0] TEST_PULSE_LEN = 32'd3;
    localparam logic [31:0] TEST_GAP       = 32'd10;

    // Down-counter value loaded on entry: the state lasts (value + 1) cycles.
    function automatic logic [31:0] state_load(
        input send_state_t s,
        input logic [31:0] p1,
        input logic [31:0] p2,
        input logic [31:0] pl,
        input logic [31:0] gap
    );
        case (s)
            WAIT_1:         return p1 - 32'd1;
            SEND_1, SEND_2: return pl - 32'd1;
            WAIT_2:         return p2 - p1 - pl - 32'd1;
            GAP_ST:         return gap - 32'd1;
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/sfp_send_scheduler_sync_2ff.sv
// Two-flop synchroniser for a single slow-changing status bit from another clock domain.
// Asynchronous active-low reset clears both stages to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sfp_send_scheduler.sv
// Periodic transmit scheduler for the two SFP send-packet channels: issues fixed-width
// cmd_send pulses with stable start addresses while MAC init and rx-ready are both up.
module sfp_send_scheduler
    import sfp_test_pkg::*;
#(
    parameter logic [31:0]       PERIOD_1     = PROD_PERIOD_1,
    parameter logic [31:0]       PERIOD_2     = PROD_PERIOD_2,
    parameter logic [31:0]       PULSE_LEN    = PROD_PULSE_LEN,
    parameter logic [31:0]       GAP          = PROD_GAP,
    parameter int unsigned       ADDR_W       = 25,
    parameter logic [ADDR_W-1:0] START_ADDR_1 = {{(ADDR_W-1){1'b0}}, 1'b1},
    parameter logic [ADDR_W-1:0] START_ADDR_2 = {{(ADDR_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk_50,
    input  logic              rst_n,
    input  logic              mac_inited_i,
    input  logic              rx_ready_i,
    output logic              cmd_send_1_o,
    output logic              cmd_send_2_o,
    output logic [ADDR_W-1:0] start_ram_addr_1_o,
    output logic [ADDR_W-1:0] start_ram_addr_2_o,
    output logic [15:0]       sent_cnt_1_o,
    output logic [15:0]       sent_cnt_2_o,
    output logic              running_o
);

    if (PERIOD_2 <= PERIOD_1 + PULSE_LEN) begin : g_bad_period
        $error("sfp_send_scheduler: PERIOD_2 must exceed PERIOD_1 + PULSE_LEN");
    end
    if (PULSE_LEN == 32'd0) begin : g_bad_pulse
        $error("sfp_send_scheduler: PULSE_LEN must be at least 1");
    end
    if (GAP == 32'd0) begin : g_bad_gap
        $error("sfp_send_scheduler: GAP must be at least 1");
    end

    logic        rdy_s;
    logic        run;
    send_state_t state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [15:0] sent_cnt_1_q, sent_cnt_2_q;

    sync_2ff u_rdy_sync (
        .clk   (clk_50),
        .rst_n (rst_n),
        .d     (rx_ready_i),
        .q     (rdy_s)
    );

    assign run = mac_inited_i & rdy_s;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (!run) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = WAIT_1;
                WAIT_1:  if (cnt == '0) state_nxt = SEND_1; else cnt_nxt = cnt - 32'd1;
                SEND_1:  if (cnt == '0) state_nxt = WAIT_2; else cnt_nxt = cnt - 32'd1;
                WAIT_2:  if (cnt == '0) state_nxt = SEND_2; else cnt_nxt = cnt - 32'd1;
                SEND_2:  if (cnt == '0) state_nxt = GAP_ST; else cnt_nxt = cnt - 32'd1;
                GAP_ST:  if (cnt == '0) state_nxt = WAIT_1; else cnt_nxt = cnt - 32'd1;
                default: state_nxt = IDLE;
            endcase
        end
        if (state_nxt != state) begin
            cnt_nxt = state_load(state_nxt, PERIOD_1, PERIOD_2, PULSE_LEN, GAP);
        end
    end

    // Outputs are registered from the next-state decode so they track the state flops exactly.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            cnt                <= '0;
            cmd_send_1_o       <= 1'b0;
            cmd_send_2_o       <= 1'b0;
            running_o          <= 1'b0;
            start_ram_addr_1_o <= '0;
            start_ram_addr_2_o <= '0;
            sent_cnt_1_q       <= '0;
            sent_cnt_2_q       <= '0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            cmd_send_1_o <= (state_nxt == SEND_1);
            cmd_send_2_o <= (state_nxt == SEND_2);
            running_o    <= (state_nxt != IDLE);
            if (state_nxt == WAIT_1 && cnt_nxt == '0) begin
                start_ram_addr_1_o <= START_ADDR_1;
            end
            if (state_nxt == WAIT_2 && cnt_nxt == '0) begin
                start_ram_addr_2_o <= START_ADDR_2;
            end
            if (state_nxt == SEND_1 && state != SEND_1) begin
                sent_cnt_1_q <= sent_cnt_1_q + 16'd1;
            end
            if (state_nxt == SEND_2 && state != SEND_2) begin
                sent_cnt_2_q <= sent_cnt_2_q + 16'd1;
            end
        end
    end

    assign sent_cnt_1_o = sent_cnt_1_q;
    assign sent_cnt_2_o = sent_cnt_2_q;

endmodule
